// File: rtl/vadd_job_sequencer.sv
// AXI4-Lite master that feeds queued VecAdd jobs to the kernel control slave:
// program n, set ap_start, then poll ap_done and report each completion.
module vadd_job_sequencer #(
  parameter int QUEUE_DEPTH = 4,
  parameter int POLL_GAP    = 4
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [63:0] job_n,
  output logic        done_pulse,
  output logic        done_err,
  output logic        busy,
  output logic        m_axi_control_AWVALID,
  input  logic        m_axi_control_AWREADY,
  output logic [4:0]  m_axi_control_AWADDR,
  output logic        m_axi_control_WVALID,
  input  logic        m_axi_control_WREADY,
  output logic [31:0] m_axi_control_WDATA,
  output logic [3:0]  m_axi_control_WSTRB,
  input  logic        m_axi_control_BVALID,
  output logic        m_axi_control_BREADY,
  input  logic [1:0]  m_axi_control_BRESP,
  output logic        m_axi_control_ARVALID,
  input  logic        m_axi_control_ARREADY,
  output logic [4:0]  m_axi_control_ARADDR,
  input  logic        m_axi_control_RVALID,
  output logic        m_axi_control_RREADY,
  input  logic [31:0] m_axi_control_RDATA,
  input  logic [1:0]  m_axi_control_RRESP
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    IDLE, WR_NLO, WR_NHI, WR_START, RD_STAT, GAP, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               job_ready_q, job_ready_d;
  logic               awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic               arvalid_q, arvalid_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               err_q, err_d;

  logic        push, pop, in_write;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_ok, w_ok;
  logic [63:0] head;
  logic        unused_rdata;

  assign push     = job_valid && job_ready_q;
  assign pop      = (state_q == DONE);
  assign in_write = (state_q == WR_NLO) || (state_q == WR_NHI) || (state_q == WR_START);
  assign head     = mem[rd_ptr_q];

  assign aw_hs = awvalid_q && m_axi_control_AWREADY;
  assign w_hs  = wvalid_q && m_axi_control_WREADY;
  assign b_hs  = in_write && m_axi_control_BVALID;
  assign ar_hs = arvalid_q && m_axi_control_ARREADY;
  assign r_hs  = (state_q == RD_STAT) && m_axi_control_RVALID;
  assign aw_ok = aw_done_q || aw_hs;
  assign w_ok  = w_done_q || w_hs;

  assign unused_rdata = ^{m_axi_control_RDATA[31:2], m_axi_control_RDATA[0], ar_hs};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
    job_ready_d = (count_d != CNT_W'(QUEUE_DEPTH));
  end

  // Each write state re-arms AW and W together; the B handshake is the only exit.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q && !m_axi_control_AWREADY;
    wvalid_d  = wvalid_q && !m_axi_control_WREADY;
    aw_done_d = aw_ok;
    w_done_d  = w_ok;
    arvalid_d = arvalid_q && !m_axi_control_ARREADY;
    gap_d     = gap_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d   = WR_NLO;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b0;
        end
      end
      WR_NLO, WR_NHI, WR_START: begin
        if (b_hs && aw_ok && w_ok) begin
          if (m_axi_control_BRESP != 2'b00) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (state_q == WR_START) begin
            state_d   = RD_STAT;
            arvalid_d = 1'b1;
          end else begin
            state_d   = (state_q == WR_NLO) ? WR_NHI : WR_START;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end
      end
      RD_STAT: begin
        if (r_hs) begin
          if (m_axi_control_RRESP != 2'b00) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else if (m_axi_control_RDATA[1]) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) begin
          state_d   = RD_STAT;
          arvalid_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      job_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      gap_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      job_ready_q <= job_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      arvalid_q   <= arvalid_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr_q] <= job_n;
  end

  always_comb begin
    m_axi_control_AWADDR = 5'h00;
    m_axi_control_WDATA  = 32'h0;
    case (state_q)
      WR_NLO: begin
        m_axi_control_AWADDR = 5'h10;
        m_axi_control_WDATA  = head[31:0];
      end
      WR_NHI: begin
        m_axi_control_AWADDR = 5'h14;
        m_axi_control_WDATA  = head[63:32];
      end
      WR_START: begin
        m_axi_control_AWADDR = 5'h00;
        m_axi_control_WDATA  = 32'h0000_0001;
      end
      default: begin
        m_axi_control_AWADDR = 5'h00;
        m_axi_control_WDATA  = 32'h0;
      end
    endcase
  end

  assign m_axi_control_AWVALID = awvalid_q;
  assign m_axi_control_WVALID  = wvalid_q;
  assign m_axi_control_WSTRB   = 4'hF;
  assign m_axi_control_BREADY  = in_write;
  assign m_axi_control_ARVALID = arvalid_q;
  assign m_axi_control_ARADDR  = 5'h00;
  assign m_axi_control_RREADY  = (state_q == RD_STAT);

  assign job_ready  = job_ready_q;
  assign done_pulse = (state_q == DONE);
  assign done_err   = (state_q == DONE) && err_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_vadd_job_sequencer.sv
// Directed bench for vadd_job_sequencer: a reactive AXI4-Lite slave on the
// falling edge plus a scoreboard of expected writes and completion flags.
module tb_vadd_job_sequencer;

  localparam int QD = 4;
  localparam int PG = 4;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [63:0] job_n;
  logic        done_pulse, done_err, busy;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [4:0]  AWADDR, ARADDR;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  vadd_job_sequencer #(.QUEUE_DEPTH(QD), .POLL_GAP(PG)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_n(job_n),
    .done_pulse(done_pulse), .done_err(done_err), .busy(busy),
    .m_axi_control_AWVALID(AWVALID), .m_axi_control_AWREADY(AWREADY),
    .m_axi_control_AWADDR(AWADDR),
    .m_axi_control_WVALID(WVALID), .m_axi_control_WREADY(WREADY),
    .m_axi_control_WDATA(WDATA), .m_axi_control_WSTRB(WSTRB),
    .m_axi_control_BVALID(BVALID), .m_axi_control_BREADY(BREADY),
    .m_axi_control_BRESP(BRESP),
    .m_axi_control_ARVALID(ARVALID), .m_axi_control_ARREADY(ARREADY),
    .m_axi_control_ARADDR(ARADDR),
    .m_axi_control_RVALID(RVALID), .m_axi_control_RREADY(RREADY),
    .m_axi_control_RDATA(RDATA), .m_axi_control_RRESP(RRESP)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  // Slave knobs, written only by the stimulus process.
  int aw_delay, w_delay, rd_done_at, err_wr_idx;
  bit ar_block;

  // Slave state and observation logs, written only by the slave process.
  bit          aw_pend, w_pend, b_act, ar_pend, r_act, seen_r, prev_arvalid, prev_done;
  int          aw_wait, w_wait, cyc, last_r_cyc;
  int          wr_cnt, aw_hs_cnt, w_hs_cnt, ar_hs_cnt, rd_cnt, done_cnt, gap_cnt;
  int          overlap_cnt, orphan_err_cnt, long_pulse_cnt, strb_bad_cnt;
  logic [4:0]  lat_addr;
  logic [31:0] lat_data;
  logic [36:0] obs_wr [256];
  logic        done_err_log [256];
  int          gap_log [256];

  // Slave acts on the falling edge: it picks its READY/VALID levels for the
  // coming rising edge, then books every handshake that edge will complete.
  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
      aw_pend = 0; w_pend = 0; b_act = 0; ar_pend = 0; r_act = 0;
      aw_wait = 0; w_wait = 0; seen_r = 0; prev_arvalid = 0; prev_done = 0;
    end else begin
      if (ARVALID && (AWVALID || WVALID)) overlap_cnt++;
      if (done_err && !done_pulse) orphan_err_cnt++;
      if (WVALID && WSTRB != 4'hF) strb_bad_cnt++;
      if (done_pulse) begin
        if (prev_done) long_pulse_cnt++;
        if (done_cnt < 256) done_err_log[done_cnt] = done_err;
        done_cnt++;
      end
      prev_done = done_pulse;
      if (ARVALID && !prev_arvalid && seen_r) begin
        if (gap_cnt < 256) gap_log[gap_cnt] = cyc - last_r_cyc;
        gap_cnt++;
        seen_r = 0;
      end
      prev_arvalid = ARVALID;

      if (AWVALID && !aw_pend) begin
        if (aw_wait >= aw_delay) AWREADY = 1;
        else begin AWREADY = 0; aw_wait++; end
      end else AWREADY = 0;
      if (WVALID && !w_pend) begin
        if (w_wait >= w_delay) WREADY = 1;
        else begin WREADY = 0; w_wait++; end
      end else WREADY = 0;
      if (!b_act && aw_pend && w_pend) begin
        b_act = 1;
        BRESP = (wr_cnt == err_wr_idx) ? 2'b10 : 2'b00;
      end
      BVALID  = b_act;
      ARREADY = ARVALID && !ar_pend && !ar_block;
      if (!r_act && ar_pend) begin
        r_act = 1;
        RDATA = (rd_cnt >= rd_done_at) ? 32'h2 : 32'h0;
        RRESP = 2'b00;
      end
      RVALID = r_act;

      if (AWVALID && AWREADY) begin aw_pend = 1; lat_addr = AWADDR; aw_hs_cnt++; aw_wait = 0; end
      if (WVALID && WREADY) begin w_pend = 1; lat_data = WDATA; w_hs_cnt++; w_wait = 0; end
      if (BVALID && BREADY) begin
        if (wr_cnt < 256) obs_wr[wr_cnt] = {lat_addr, lat_data};
        wr_cnt++;
        aw_pend = 0; w_pend = 0; b_act = 0;
      end
      if (ARVALID && ARREADY) begin ar_pend = 1; ar_hs_cnt++; end
      if (RVALID && RREADY) begin
        r_act = 0; ar_pend = 0; rd_cnt++; last_r_cyc = cyc; seen_r = !RDATA[1];
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [36:0] exp_wr [$];
  logic        exp_err [$];
  int          wr_rd = 0;
  int          done_rd = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one job at a falling edge and, once accepted, books its expected writes.
  task automatic applyStimulus(input logic [63:0] n, input int nWrites, input bit pushDone,
                               input bit errFlag, output bit accepted);
    int waited;
    waited    = 0;
    job_valid = 1'b1;
    job_n     = n;
    while (!job_ready && waited < 40) begin
      @(negedge ap_clk);
      waited++;
    end
    accepted = job_ready;
    @(negedge ap_clk);
    job_valid = 1'b0;
    if (accepted) begin
      if (nWrites > 0) exp_wr.push_back({5'h10, n[31:0]});
      if (nWrites > 1) exp_wr.push_back({5'h14, n[63:32]});
      if (nWrites > 2) exp_wr.push_back({5'h00, 32'h1});
      if (pushDone) exp_err.push_back(errFlag);
    end
  endtask

  task automatic waitDone(input string tag, input int target, input int bound);
    int waited;
    waited = 0;
    while (done_cnt < target && waited < bound) begin
      @(negedge ap_clk);
      waited++;
    end
    checkOutput({tag, "_done_count"}, done_cnt, target);
  endtask

  task automatic drainScoreboard(input string tag);
    logic [36:0] e;
    logic        ee;
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      checkOutput({tag, "_write"}, (wr_rd < wr_cnt) ? obs_wr[wr_rd] : 37'h1F_FFFF_FFFF, e);
      wr_rd++;
    end
    checkOutput({tag, "_write_total"}, wr_cnt, wr_rd);
    while (exp_err.size() > 0) begin
      ee = exp_err.pop_front();
      checkOutput({tag, "_done_err"}, (done_rd < done_cnt) ? done_err_log[done_rd] : 1'bx, ee);
      done_rd++;
    end
    checkOutput({tag, "_done_total"}, done_cnt, done_rd);
  endtask

  initial begin
    bit acc;
    int base_ar, base_aw, base_w, base_gap, base_done, waited;

    job_valid = 0; job_n = 0; ap_rst_n = 0;
    aw_delay = 0; w_delay = 0; ar_block = 0; rd_done_at = 0; err_wr_idx = -1;

    // Reset state
    repeat (3) @(negedge ap_clk);
    checkOutput("reset_outputs",
                {AWVALID, WVALID, BREADY, ARVALID, RREADY, done_pulse, done_err, busy, job_ready}, 0);
    ap_rst_n = 1;
    @(negedge ap_clk);
    checkOutput("ready_after_reset", job_ready, 1);

    // Single job, done on first read, plus push-to-AWVALID latency
    rd_done_at = rd_cnt;
    base_ar = ar_hs_cnt;
    applyStimulus(64'd5, 3, 1, 0, acc);
    checkOutput("t1_accept", acc, 1);
    checkOutput("t1_aw_not_yet", AWVALID, 0);
    @(negedge ap_clk);
    checkOutput("t1_aw_latency", AWVALID, 1);
    waitDone("t1", done_rd + 1, 40);
    drainScoreboard("t1");
    checkOutput("t1_ar_count", ar_hs_cnt - base_ar, 1);
    repeat (2) @(negedge ap_clk);
    checkOutput("t1_busy_low", busy, 0);

    // Done only on the third status read; re-polls honour the gap
    rd_done_at = rd_cnt + 2;
    base_ar = ar_hs_cnt;
    base_gap = gap_cnt;
    applyStimulus(64'h0000_0002_0000_0007, 3, 1, 0, acc);
    checkOutput("t2_accept", acc, 1);
    waitDone("t2", done_rd + 1, 100);
    drainScoreboard("t2");
    checkOutput("t2_ar_count", ar_hs_cnt - base_ar, 3);
    checkOutput("t2_gap_count", gap_cnt - base_gap, 2);
    for (int i = base_gap; i < gap_cnt && i < 256; i++)
      checkOutput("t2_gap_ok", gap_log[i] >= PG + 1, 1);

    // Slow AWREADY, then slow WREADY
    for (int k = 0; k < 2; k++) begin
      aw_delay = (k == 0) ? 3 : 0;
      w_delay  = (k == 0) ? 0 : 3;
      rd_done_at = rd_cnt;
      base_aw = aw_hs_cnt;
      base_w  = w_hs_cnt;
      applyStimulus((k == 0) ? 64'h1234_5678_9ABC_DEF0 : 64'hCAFE_0000_0000_0011, 3, 1, 0, acc);
      checkOutput("t3_accept", acc, 1);
      waitDone("t3", done_rd + 1, 80);
      drainScoreboard("t3");
      checkOutput("t3_aw_count", aw_hs_cnt - base_aw, 3);
      checkOutput("t3_w_count", w_hs_cnt - base_w, 3);
    end
    aw_delay = 0;
    w_delay  = 0;

    // Fill the queue while the kernel never finishes
    rd_done_at = 32'h7FFF_FFFF;
    base_done = done_cnt;
    for (int j = 0; j < QD; j++) begin
      applyStimulus(64'd100 + 64'(j), 3, 1, 0, acc);
      checkOutput("t4_accept", acc, 1);
    end
    job_valid = 1;
    job_n = 64'd105;
    repeat (10) @(negedge ap_clk);
    checkOutput("t4_full_ready", job_ready, 0);
    checkOutput("t4_busy", busy, 1);
    checkOutput("t4_no_done_yet", done_cnt - base_done, 0);
    rd_done_at = rd_cnt;
    waited = 0;
    while (!job_ready && waited < 200) begin
      @(negedge ap_clk);
      waited++;
    end
    checkOutput("t4_ready_after_done", job_ready, 1);
    @(negedge ap_clk);
    job_valid = 0;
    exp_wr.push_back({5'h10, 32'd105});
    exp_wr.push_back({5'h14, 32'd0});
    exp_wr.push_back({5'h00, 32'h1});
    exp_err.push_back(1'b0);
    checkOutput("t4_refull", job_ready, 0);
    checkOutput("t4_one_done", done_cnt - base_done, 1);
    waitDone("t4", base_done + QD + 1, 400);
    drainScoreboard("t4");

    // Error response on the 0x14 write, then a normal job behind it
    rd_done_at = rd_cnt;
    err_wr_idx = wr_cnt + 1;
    base_ar = ar_hs_cnt;
    applyStimulus(64'd9, 2, 1, 1, acc);
    checkOutput("t5_accept_a", acc, 1);
    applyStimulus(64'd3, 3, 1, 0, acc);
    checkOutput("t5_accept_b", acc, 1);
    waitDone("t5", done_rd + 2, 120);
    drainScoreboard("t5");
    checkOutput("t5_ar_count", ar_hs_cnt - base_ar, 1);

    // Reset while ARVALID waits on a stalled slave
    ar_block = 1;
    rd_done_at = rd_cnt;
    base_ar = ar_hs_cnt;
    base_done = done_cnt;
    applyStimulus(64'd4, 3, 0, 0, acc);
    checkOutput("t6_accept_a", acc, 1);
    applyStimulus(64'd6, 0, 0, 0, acc);
    checkOutput("t6_accept_b", acc, 1);
    waited = 0;
    while (!ARVALID && waited < 50) begin
      @(negedge ap_clk);
      waited++;
    end
    checkOutput("t6_arvalid", ARVALID, 1);
    #2 ap_rst_n = 0;
    #1 checkOutput("t6_reset_outputs",
                   {AWVALID, WVALID, BREADY, ARVALID, RREADY, done_pulse, done_err, busy, job_ready}, 0);
    @(negedge ap_clk);
    ap_rst_n = 1;
    ar_block = 0;
    repeat (20) @(negedge ap_clk);
    checkOutput("t6_no_done", done_cnt - base_done, 0);
    checkOutput("t6_no_ar", ar_hs_cnt - base_ar, 0);
    checkOutput("t6_idle", {busy, job_ready}, 2'b01);
    drainScoreboard("t6");

    // Protocol invariants over the whole run
    checkOutput("ar_aw_overlap", overlap_cnt, 0);
    checkOutput("err_without_pulse", orphan_err_cnt, 0);
    checkOutput("long_done_pulse", long_pulse_cnt, 0);
    checkOutput("wstrb", strb_bad_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
